cpu32: RTL and testbench

- Single-cycle 32-bit accumulator-free CPU core with a 16-entry x 32-bit register file ("mem") and an 8-bit program counter.
- Fetches a 16-bit instruction from an external combinational program ROM addressed by pc.
- Executes load-immediate, ALU (carry-lookahead add/sub plus logic) and conditional-branch instructions, one per clock.
- Exposes decode and write-back signals for trace and monitoring.

---
 rtl/cpu32_pkg.sv | 17 +
 rtl/cla32.sv | 28 ++
 rtl/cpu32.sv | 75 +++++++
 tb/tb_cpu32.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu32_pkg.sv
// rtl/cpu32_pkg.sv - shared opcodes and widths for the cpu32 core
package cpu32_pkg;
  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int REG_N  = 16;

  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_BZ    = 4'h8;
  localparam logic [3:0] OP_BNZ   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;
endpackage

// File: rtl/cla32.sv
// rtl/cla32.sv - 32-bit adder from eight 4-bit carry-lookahead groups
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [7:0] c;
  assign c[0] = cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] cc;
    assign p = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign g = a[4*gi +: 4] & b[4*gi +: 4];
    assign cc[0] = c[gi];
    assign cc[1] = g[0] | (p[0] & cc[0]);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cc[0]);
    assign sum[4*gi +: 4] = p ^ cc;
    // The final group's carry-out is dropped: arithmetic wraps modulo 2^32.
    if (gi < 7) begin : g_co
      assign c[gi+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]) | (&p & cc[0]);
    end
  end
endmodule

// File: rtl/cpu32.sv
// rtl/cpu32.sv - single-cycle 32-bit CPU: decode, 16x32 register file, 8-bit pc
module cpu32
  import cpu32_pkg::*;
(
  input  logic              clk,
  input  logic              power,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] mem_s,
  input  logic [15:0]       code,
  output logic              write_en,
  output logic              imm_en,
  output logic              branch_en,
  output logic [PC_W-1:0]   next_pc
);
  logic [DATA_W-1:0] mem_q [REG_N];
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;

  logic [3:0]        op, rd, ra, rb;
  logic [DATA_W-1:0] a_val, b_val, add_b, add_sum;
  logic              is_sub;

  assign op    = code[15:12];
  assign rd    = code[11:8];
  assign ra    = code[7:4];
  assign rb    = code[3:0];
  assign a_val = mem_q[ra];
  assign b_val = mem_q[rb];

  // Subtraction reuses the adder as a + ~b + 1.
  assign is_sub = (op == OP_SUB);
  assign add_b  = is_sub ? ~b_val : b_val;

  cla32 u_cla (
    .a   (a_val),
    .b   (add_b),
    .cin (is_sub),
    .sum (add_sum)
  );

  always_comb begin
    mem_s     = a_val;
    write_en  = 1'b0;
    imm_en    = 1'b0;
    branch_en = 1'b0;
    pc_d      = pc_q + 8'd1;
    case (op)
      OP_LOADI: begin mem_s = {{24{code[7]}}, code[7:0]}; imm_en = 1'b1; end
      OP_ADD,
      OP_SUB:   begin mem_s = add_sum;         write_en = 1'b1; end
      OP_AND:   begin mem_s = a_val & b_val;   write_en = 1'b1; end
      OP_OR:    begin mem_s = a_val | b_val;   write_en = 1'b1; end
      OP_XOR:   begin mem_s = a_val ^ b_val;   write_en = 1'b1; end
      OP_NOT:   begin mem_s = ~a_val;          write_en = 1'b1; end
      OP_BZ:    branch_en = (a_val == '0);
      OP_BNZ:   branch_en = (a_val != '0);
      OP_HALT:  pc_d = pc_q;
      default:  ;
    endcase
    if (branch_en) pc_d = {code[11:8], code[3:0]};
  end

  assign next_pc = pc_d;
  assign pc      = pc_q;

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      pc_q <= '0;
      for (int i = 0; i < REG_N; i++) mem_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (write_en | imm_en) mem_q[rd] <= mem_s;
    end
  end
endmodule

// File: tb/tb_cpu32.sv
// tb/tb_cpu32.sv - self-checking bench for cpu32 against a behavioural model
module tb_cpu32;
  logic        clk = 1'b0;
  logic        power = 1'b0;
  logic [15:0] code = 16'h0000;
  logic [7:0]  pc, next_pc;
  logic [31:0] mem_s;
  logic        write_en, imm_en, branch_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [16];
  logic [7:0]  m_pc;

  cpu32 dut (
    .clk       (clk),
    .power     (power),
    .pc        (pc),
    .mem_s     (mem_s),
    .code      (code),
    .write_en  (write_en),
    .imm_en    (imm_en),
    .branch_en (branch_en),
    .next_pc   (next_pc)
  );

  always #5 clk = ~clk;

  function automatic void model_eval(input logic [15:0] c, output logic [31:0] s,
                                     output logic we, output logic ie, output logic be,
                                     output logic [7:0] npc);
    logic [31:0] a, b;
    a = m_mem[c[7:4]];
    b = m_mem[c[3:0]];
    s = a; we = 1'b0; ie = 1'b0; be = 1'b0;
    npc = m_pc + 8'd1;
    case (c[15:12])
      4'h1: begin s = 32'($signed(c[7:0])); ie = 1'b1; end
      4'h2: begin s = a + b;  we = 1'b1; end
      4'h3: begin s = a - b;  we = 1'b1; end
      4'h4: begin s = a & b;  we = 1'b1; end
      4'h5: begin s = a | b;  we = 1'b1; end
      4'h6: begin s = a ^ b;  we = 1'b1; end
      4'h7: begin s = ~a;     we = 1'b1; end
      4'h8: if (a == 0) begin be = 1'b1; npc = {c[11:8], c[3:0]}; end
      4'h9: if (a != 0) begin be = 1'b1; npc = {c[11:8], c[3:0]}; end
      4'hF: npc = m_pc;
      default: ;
    endcase
  endfunction

  function automatic logic [42:0] model_outs(input logic [15:0] c);
    logic [31:0] s; logic we, ie, be; logic [7:0] npc;
    model_eval(c, s, we, ie, be, npc);
    return {s, we, ie, be, npc};
  endfunction

  task automatic model_reset();
    m_pc = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
  endtask

  task automatic drive(input logic [15:0] c);
    code = c;
    #1;
  endtask

  task automatic tick();
    logic [31:0] s; logic we, ie, be; logic [7:0] npc;
    model_eval(code, s, we, ie, be, npc);
    @(posedge clk);
    #1;
    if (we | ie) m_mem[code[11:8]] = s;
    m_pc = npc;
  endtask

  task automatic test_reset();
    model_reset();
    power = 1'b0;
    code  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    for (int r = 0; r < 16; r++) begin
      drive({8'h00, 4'(r), 4'h0});
      checks++;
      if (mem_s !== 32'h0) begin errors++; $display("FAIL reset_mem%0d: got %h want 0", r, mem_s); end
    end
    @(negedge clk);
    power = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] codes [13] = '{16'h1105, 16'h12FD, 16'h2312, 16'h1207, 16'h3412, 16'h5512,
                                16'h6612, 16'h7710, 16'h8A03, 16'h9A03, 16'h8F0F, 16'h0000, 16'h8009};
    logic [31:0] exp_s [13]  = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h7, 32'hFFFFFFFE, 32'h7,
                                32'h2, 32'hFFFFFFFA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  exp_f [13]  = '{3'b010, 3'b010, 3'b100, 3'b010, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
    logic [7:0]  exp_pc [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'hA3, 8'hA4, 8'hFF, 8'h00, 8'h09};
    for (int i = 0; i < 13; i++) begin
      drive(codes[i]);
      checks++;
      if ({mem_s, write_en, imm_en, branch_en, next_pc} !== {exp_s[i], exp_f[i], exp_pc[i]})
      begin
        errors++;
        $display("FAIL directed_%h: got s=%h f=%b npc=%h want s=%h f=%b npc=%h", codes[i],
                 mem_s, {write_en, imm_en, branch_en}, next_pc, exp_s[i], exp_f[i], exp_pc[i]);
      end
      tick();
      checks++;
      if (pc !== exp_pc[i]) begin errors++; $display("FAIL directed_pc_%0d: got %h want %h", i, pc, exp_pc[i]); end
    end
  endtask

  task automatic test_halt();
    drive(16'hF000);
    checks++;
    if ({write_en, imm_en, branch_en, next_pc} !== {3'b000, 8'h09}) begin
      errors++;
      $display("FAIL halt_decode: got f=%b npc=%h want f=000 npc=09",
               {write_en, imm_en, branch_en}, next_pc);
    end
    repeat (3) begin
      tick();
      checks++;
      if (pc !== 8'h09) begin errors++; $display("FAIL halt_pc: got %h want 09", pc); end
    end
    for (int r = 0; r < 16; r++) begin
      drive({8'hF0, 4'(r), 4'h0});
      checks++;
      if (mem_s !== m_mem[r]) begin errors++; $display("FAIL halt_mem%0d: got %h want %h", r, mem_s, m_mem[r]); end
    end
    checks++;
    if (pc !== 8'h09 || next_pc !== 8'h09) begin errors++; $display("FAIL halt_hold: got pc=%h npc=%h want 09", pc, next_pc); end
  endtask

  task automatic test_random_back_to_back();
    logic [15:0] c;
    logic [42:0] exp;
    for (int i = 0; i < 300; i++) begin
      c = 16'($urandom);
      if (i % 7 == 0) c[15:12] = 4'h1;
      drive(c);
      exp = model_outs(c);
      checks++;
      if ({mem_s, write_en, imm_en, branch_en, next_pc} !== exp) begin
        errors++;
        $display("FAIL random_%0d code=%h: got %h want %h", i, c,
                 {mem_s, write_en, imm_en, branch_en, next_pc}, exp);
      end
      tick();
      checks++;
      if (pc !== m_pc) begin errors++; $display("FAIL random_pc_%0d: got %h want %h", i, pc, m_pc); end
    end
  endtask

  task automatic test_async_reset();
    drive(16'h1105);
    tick();
    drive(16'h2311);
    #2;
    power = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL async_pc: got %h want 00", pc); end
    for (int r = 0; r < 16; r++) begin
      drive({8'h00, 4'(r), 4'h0});
      checks++;
      if (mem_s !== 32'h0) begin errors++; $display("FAIL async_mem%0d: got %h want 0", r, mem_s); end
    end
    drive(16'h2311);
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL async_hold_pc: got %h want 00", pc); end
    @(negedge clk);
    power = 1'b1;
    drive(16'h1105);
    tick();
    drive(16'h0010);
    checks++;
    if (pc !== 8'h01 || mem_s !== 32'h5) begin
      errors++;
      $display("FAIL async_restart: got pc=%h mem1=%h want pc=01 mem1=5", pc, mem_s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_halt();
    test_random_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
